// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller.
// Handles three things:
//   - branch redirects from stage BR_STAGE
//   - serialising instructions held in decode
//   - trap entry: drain the pipeline, then redirect fetch to the trap vector
//
// Handshake for trap_req/trap_insert:
//   - trap_req is a level request that the source holds.
//   - The request is accepted in RUN, and the vector is captured at that moment.
//   - trap_insert pulses for one cycle when the trap is actually taken.
//   - The source drops trap_req on that same cycle.
//
// All outputs are combinational from the registered state and the current
// inputs. state_dbg exposes the FSM state with this encoding:
//   0 = RUN, 1 = SERIAL, 2 = DRAIN, 3 = TRAP
module pipe_ctrl #(
  parameter int XLEN     = 32,
  parameter int NSTAGE   = 3,
  parameter int BR_STAGE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stage_valid,
  input  logic              stall_in,
  input  logic              branch,
  input  logic [XLEN-1:0]   branch_addr,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_addr,
  input  logic              serial_req,
  output logic              next_pc_en,
  output logic [XLEN-1:0]   next_pc,
  output logic              bubble_fetch,
  output logic [NSTAGE-1:0] flush,
  output logic              trap_insert,
  output logic              serial_pending,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SERIAL = 2'd1,
    DRAIN  = 2'd2,
    TRAP   = 2'd3
  } state_e;

  // Stages younger than the branch-resolving stage are the wrong path.
  localparam logic [NSTAGE-1:0] FLUSH_MASK = NSTAGE'((32'd1 << BR_STAGE) - 32'd1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   tvec_q, tvec_d;
  logic              br_q, ser_q, empty;

  // Requests count only when the stage that raises them holds a real instruction.
  assign br_q      = branch & stage_valid[BR_STAGE];
  assign ser_q     = serial_req & stage_valid[0];
  assign empty     = (stage_valid == '0);
  assign state_dbg = state_q;

  // State and captured trap vector; reset aborts any pending serialise or trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tvec_q  <= '0;
    end else begin
      state_q <= state_d;
      tvec_q  <= tvec_d;
    end
  end

  // Next-state logic and the redirect/bubble/flush outputs.
  always_comb begin
    state_d        = state_q;
    tvec_d         = tvec_q;
    next_pc_en     = 1'b0;
    next_pc        = tvec_q;
    bubble_fetch   = 1'b0;
    flush          = '0;
    trap_insert    = 1'b0;
    serial_pending = (state_q == SERIAL);

    // A taken branch redirects fetch in every state except the trap cycle.
    // Stalls never hold it back.
    if (br_q && (state_q != TRAP)) begin
      next_pc_en   = 1'b1;
      next_pc      = branch_addr;
      bubble_fetch = 1'b1;
      flush        = FLUSH_MASK;
    end

    case (state_q)
      RUN: begin
        // A trap wins over a serialise request.
        // A branch in the same cycle still redirects, and the trap is still
        // accepted. A serialise request in the same cycle as a branch is on
        // the flushed path, so it is dropped.
        if (trap_req) begin
          tvec_d  = trap_addr;
          state_d = DRAIN;
        end else if (ser_q && !br_q) begin
          state_d = SERIAL;
        end
      end
      SERIAL: begin
        // Starve fetch until the serialising instruction has left the pipe.
        bubble_fetch = 1'b1;
        if (empty && !stall_in) state_d = RUN;
      end
      DRAIN: begin
        // Let older instructions retire before the trap is taken.
        bubble_fetch = 1'b1;
        if (empty && !stall_in) state_d = TRAP;
      end
      TRAP: begin
        trap_insert  = 1'b1;
        next_pc_en   = 1'b1;
        next_pc      = tvec_q;
        bubble_fetch = 1'b1;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of all address ports.
REQ-002 SHALL have parameter NSTAGE, default 3, legal 2..8: number of tracked stages after fetch; bit 0 is decode.
REQ-003 SHALL have parameter BR_STAGE, default 1, legal 0..NSTAGE-1: stage index that resolves branches.
REQ-004 SHALL have port clk  in  1: single clock, rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port stage_valid  in  NSTAGE: per-stage valid; 0 marks a bubble.
REQ-007 SHALL have port stall_in  in  1: pipeline not advancing this cycle (memory wait).
REQ-008 SHALL have port branch  in  1: taken branch/jump from stage BR_STAGE.
REQ-009 SHALL have port branch_addr  in  XLEN: branch target.
REQ-010 SHALL have port trap_req  in  1: trap/interrupt request, level, held by source until trap_insert.
REQ-011 SHALL have port trap_addr  in  XLEN: trap vector.
REQ-012 SHALL have port serial_req  in  1: decode holds a serialising instruction (atomic CSR, fence).
REQ-013 SHALL have port next_pc_en  out  1: redirect fetch this cycle.
REQ-014 SHALL have port next_pc  out  XLEN: redirect target.
REQ-015 SHALL have port bubble_fetch  out  1: fetch injects a bubble this cycle.
REQ-016 SHALL have port flush  out  NSTAGE: invalidate stage i this cycle.
REQ-017 SHALL have port trap_insert  out  1: trap taken this cycle.
REQ-018 SHALL have port serial_pending  out  1: high in SERIAL state.

Function
REQ-019 SHALL qualify br_q = branch & stage_valid[BR_STAGE] and ser_q = serial_req & stage_valid[0]; unqualified requests are ignored.
REQ-020 SHALL define empty = (stage_valid == 0).
REQ-021 SHALL implement states RUN, SERIAL, DRAIN, TRAP; registered state, combinational outputs.
REQ-022 On br_q in any state except TRAP: next_pc_en=1, next_pc=branch_addr, bubble_fetch=1, flush[i]=1 for all i<BR_STAGE, same cycle.
REQ-023 RUN: trap_req -> latch trap_addr into tvec_q, go DRAIN; else ser_q & !br_q -> SERIAL; else stay.
REQ-024 br_q with trap_req in RUN: branch redirect taken and trap still accepted to DRAIN; br_q with ser_q: serial request dropped (flushed).
REQ-025 SERIAL: bubble_fetch=1; exit to RUN when empty & !stall_in; trap_req ignored until exit.
REQ-026 DRAIN: bubble_fetch=1; go TRAP when empty & !stall_in; else hold.
REQ-027 TRAP lasts exactly one cycle: trap_insert=1, next_pc_en=1, next_pc=tvec_q, bubble_fetch=1; next state RUN.
REQ-028 tvec_q SHALL be captured only on RUN->DRAIN; later changes of trap_addr have no effect on that trap.
REQ-029 next_pc SHALL equal tvec_q when not redirecting on a branch and not in TRAP (no undriven value).
REQ-030 stall_in SHALL only gate exits from SERIAL/DRAIN; it never suppresses a br_q redirect.
REQ-031 flush bits for i>=BR_STAGE SHALL never assert.

Reset
REQ-032 rst high SHALL force state RUN, tvec_q=0 immediately, asynchronously, aborting any SERIAL/DRAIN/TRAP.
REQ-033 During and after reset with inputs low: next_pc_en=0, next_pc=0, bubble_fetch=0, flush=0, trap_insert=0, serial_pending=0.
REQ-034 First state transition SHALL occur on the first rising clk after rst deasserts.

Verification
REQ-035 Branch: stage_valid=3'b111, branch=1, branch_addr=0x100 -> same cycle next_pc_en=1, next_pc=0x100, flush=3'b001, state stays RUN.
REQ-036 Trap drain: trap_req=1, trap_addr=0x80 with stage_valid=3'b110, trap_addr changed to 0x90 next cycle, valid clears after 2 cycles -> bubble_fetch high 2 cycles, then one cycle trap_insert=1, next_pc=0x80.
REQ-037 Serialise: serial_req=1, stage_valid=3'b001 -> serial_pending=1 from next cycle; trap_req raised meanwhile; after empty & !stall_in -> RUN, then DRAIN, trap taken.
REQ-038 Stall: DRAIN with empty=1, stall_in=1 for 3 cycles -> no trap_insert until first cycle after stall_in falls.
REQ-039 Ignored requests: branch=1 with stage_valid[1]=0, serial_req=1 with stage_valid[0]=0 -> no redirect, no flush, state RUN.
REQ-040 Reset mid-DRAIN: rst pulsed between clock edges -> state RUN and all outputs 0 before next edge; no trap_insert afterwards unless trap_req reasserted.
